fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Downstream consumer of the 8-bit byte FIFO: drains bytes and serializes each as an
//  8N1-style UART frame (start, 8 data LSB-first, STOP_BITS stop) on a single TX line.
//  Sits between the FIFO read side and the board UART pin. Issues a one-cycle dequeue
//  per byte consumed. Frames go out back-to-back while the FIFO is non-empty.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per UART bit (50 MHz / 115200); legal >= 2
//  STOP_BITS     1    number of stop bits, 1 or 2
// PORTS
//  clk           in   1  system clock, all logic on rising edge
//  rst_n         in   1  asynchronous reset, active low
//  en            in   1  transmit enable; gates only the start of a new frame
//  fifo_empty    in   1  FIFO empty flag
//  fifo_dout     in   8  FIFO head byte; valid whenever fifo_empty=0 (first-word fall-through)
//  fifo_dequeue  out  1  one-cycle pop strobe to FIFO
//  tx            out  1  serial line, idle high; registered
//  busy          out  1  high while a frame is on the line
// BEHAVIOUR
//  Reset (async, rst_n=0): tx=1, busy=0, fifo_dequeue=0, state=IDLE, counters=0, shift reg=0.
//  States: IDLE, START, DATA, STOP. bit_cnt 0..7 (DATA), 0..STOP_BITS-1 (STOP);
//   baud_cnt 0..CLKS_PER_BIT-1.
//  Load condition L = en & ~fifo_empty, evaluated in IDLE or in last cycle of STOP.
//  IDLE: if L: fifo_dequeue=1 (combinational, this cycle only), latch fifo_dout into
//   shift reg at edge, go START, tx=0, busy=1, baud_cnt=0. Else stay; tx=1, busy=0.
//  START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_cnt=0.
//  DATA: tx=shift[0]; each bit held CLKS_PER_BIT cycles; shift right at bit end;
//   after bit 7 go STOP.
//  STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On final cycle: if L, pop and go START
//   (zero idle gap, frame N+1 start bit immediately follows stop); else go IDLE, busy=0.
//  Frame length exactly (9+STOP_BITS)*CLKS_PER_BIT cycles; tx changes only on frame-
//   relative multiples of CLKS_PER_BIT.
//  fifo_dequeue: exactly one pulse per frame, in the cycle the byte is latched; never
//   asserted when fifo_empty=1; never asserted mid-frame.
//  en deassert mid-frame: current frame completes unaltered; no new frame loaded.
//  fifo_empty rising mid-frame: no effect on current frame.
//  fifo_dout changing after latch: no effect (byte captured in shift reg).
//  Reset mid-frame: tx returns high immediately (async), frame aborted, FIFO untouched.
//  First edge after rst_n release: behaves as IDLE; may load if L.
//  Counters sized $clog2(CLKS_PER_BIT); no wrap beyond CLKS_PER_BIT-1.
// TESTING (CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
//  1 Idle: en=1, fifo_empty=1 for 100 cycles -> tx=1, busy=0, fifo_dequeue never 1.
//  2 Single byte 0x09: one dequeue pulse; tx sampled mid-bit = 0,1,0,0,1,0,0,0,0,1
//    (start, LSB-first data, stop); busy high exactly 40 cycles.
//  3 Back-to-back 0x09 then 0x08 queued: dequeue pulses exactly 40 cycles apart; second
//    start bit begins the cycle after first stop ends; data 0,0,0,1,0,0,0,0; 80 cycles busy.
//  4 en dropped at cycle 10 of frame with FIFO non-empty: frame finishes (40 cycles),
//    then tx=1, busy=0, no further dequeue until en=1 again.
//  5 rst_n pulsed low at cycle 17 of frame: tx=1 and busy=0 same cycle; after release
//    with FIFO non-empty and en=1, next frame starts with a fresh dequeue.
//  6 STOP_BITS=2, byte 0xFF: start 4 cycles low, then 40 cycles high; frame = 44 cycles.

Source files
------------

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fifo_uart_tx                                                    |
// | Purpose  : Drains a first-word-fall-through byte FIFO and serializes each  |
// |            byte as a UART frame (start, 8 data LSB-first, stop bits).      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_dequeue,
  output logic       tx,
  output logic       busy
);

  localparam int               c_cnt_w     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       c_stop_last = 3'(STOP_BITS - 1);
  localparam logic [2:0]       c_data_last = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_baud;
  logic [c_cnt_w-1:0]   w_baud_nxt;
  logic [2:0]           r_bit;
  logic [2:0]           w_bit_nxt;
  logic [7:0]           r_shift;
  logic [7:0]           w_shift_nxt;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic                 w_load;
  logic                 w_baud_last;
  logic                 w_deq;

  // State, counters, shift register and the registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state logic; tx/busy are derived from the next state so they are
  // registered and change exactly on bit boundaries.
  always_comb begin
    w_load      = en & ~fifo_empty;
    w_baud_last = (r_baud == c_baud_last);
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_deq       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_deq       = 1'b1;
          w_shift_nxt = fifo_dout;
          w_state_nxt = S_START;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end
      end
      S_START: begin
        if (w_baud_last) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == c_data_last) begin
            w_state_nxt = S_STOP;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      S_STOP: begin
        if (w_baud_last) begin
          w_baud_nxt = '0;
          if (r_bit == c_stop_last) begin
            w_bit_nxt = '0;
            // Chain straight into the next start bit when another byte waits.
            if (w_load) begin
              w_deq       = 1'b1;
              w_shift_nxt = fifo_dout;
              w_state_nxt = S_START;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // The pop strobe is combinational; holding it low during reset keeps the
  // FIFO untouched while the state register is forced to idle.
  assign fifo_dequeue = w_deq & rst_n;
  assign tx           = r_tx;
  assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fifo_uart_tx                                                 |
// | Purpose  : Scoreboard bench for fifo_uart_tx; two instances (one and two   |
// |            stop bits) share stimulus, a line decoder checks every frame.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [1:0]      fifo_empty;
  logic [1:0][7:0] fifo_dout;
  logic [1:0]      fifo_dequeue;
  logic [1:0]      tx;
  logic [1:0]      busy;

  int checks   = 0;
  int failures = 0;

  // FIFO contents per instance and expected frame bytes per instance.
  logic [7:0] fq    [2][$];
  logic [7:0] exp_q [2][$];

  // Line decoder state (monitor only).
  logic [1:0] inf;
  logic [1:0] prev_deq;
  logic [1:0] pop_req;
  int         cyc [2];
  logic [10:0] fb [2];
  logic       started;
  logic       stops_ok;
  logic [7:0] data_b;
  logic [7:0] exp_b;
  int         flen;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .fifo_empty(fifo_empty[0]), .fifo_dout(fifo_dout[0]),
    .fifo_dequeue(fifo_dequeue[0]), .tx(tx[0]), .busy(busy[0])
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .fifo_empty(fifo_empty[1]), .fifo_dout(fifo_dout[1]),
    .fifo_dequeue(fifo_dequeue[1]), .tx(tx[1]), .busy(busy[1])
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic string nm(input string s, input int d);
    return $sformatf("%s[dut%0d]", s, d);
  endfunction

  // FIFO model: pops whatever was dequeued in the previous cycle, then
  // presents the head (garbage when empty) shortly after the edge.
  always begin
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (pop_req[d] && fq[d].size() > 0) void'(fq[d].pop_front());
      fifo_empty[d] = (fq[d].size() == 0);
      fifo_dout[d]  = fifo_empty[d] ? 8'($urandom) : fq[d][0];
    end
  end

  // Line decoder: recognises frames on tx, samples mid-bit, and checks
  // framing, data, busy and dequeue behaviour against the expected bytes.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      flen = (10 + d) * CPB;
      if (!rst_n) begin
        chk(tx[d] == 1'b1 && busy[d] == 1'b0 && fifo_dequeue[d] == 1'b0, nm("reset_out", d),
            int'({tx[d], busy[d], fifo_dequeue[d]}), 4);
        if (inf[d] && exp_q[d].size() > 0) void'(exp_q[d].pop_front());
        inf[d]      = 1'b0;
        prev_deq[d] = 1'b0;
        pop_req[d]  = 1'b0;
      end else begin
        started = 1'b0;
        if (inf[d]) begin
          cyc[d]++;
        end else if (tx[d] == 1'b0) begin
          started = 1'b1;
          inf[d]  = 1'b1;
          cyc[d]  = 0;
          fb[d]   = '0;
        end
        if (started || prev_deq[d])
          chk(started == prev_deq[d], nm("deq_start_pair", d), int'(started), int'(prev_deq[d]));
        chk(busy[d] == inf[d], nm("busy", d), int'(busy[d]), int'(inf[d]));
        if (fifo_dequeue[d]) begin
          chk(!fifo_empty[d], nm("deq_when_empty", d), int'(fifo_empty[d]), 0);
          chk(!inf[d] || cyc[d] == flen - 1, nm("deq_mid_frame", d), cyc[d], flen - 1);
        end
        if (inf[d]) begin
          if (cyc[d] % CPB == CPB / 2) fb[d][cyc[d] / CPB] = tx[d];
          if (cyc[d] == flen - 1) begin
            data_b   = fb[d][8:1];
            stops_ok = 1'b1;
            for (int s = 0; s <= d; s++) if (fb[d][9 + s] !== 1'b1) stops_ok = 1'b0;
            chk(fb[d][0] == 1'b0, nm("start_bit", d), int'(fb[d][0]), 0);
            chk(stops_ok, nm("stop_bits", d), int'(fb[d][10:9]), (d == 0) ? 1 : 3);
            if (exp_q[d].size() == 0) begin
              chk(1'b0, nm("unexpected_frame", d), int'(data_b), -1);
            end else begin
              exp_b = exp_q[d].pop_front();
              chk(data_b == exp_b, nm("data", d), int'(data_b), int'(exp_b));
            end
            inf[d] = 1'b0;
          end
        end
        prev_deq[d] = fifo_dequeue[d];
        pop_req[d]  = fifo_dequeue[d];
      end
    end
  end

  task automatic push(input logic [7:0] b);
    for (int d = 0; d < 2; d++) begin
      fq[d].push_back(b);
      exp_q[d].push_back(b);
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((fq[0].size() != 0 || fq[1].size() != 0 || inf != 2'b00 || busy != 2'b00) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(n < bound, "drain_timeout", n, bound);
  endtask

  task automatic wait_start();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!inf[0] && n < 200);
    chk(inf[0] == 1'b1, "start_timeout", n, 200);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy != 2'b00 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(busy == 2'b00, "idle_timeout", int'(busy), 0);
  endtask

  initial begin
    inf      = '0;
    prev_deq = '0;
    pop_req  = '0;
    en       = 1'b1;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle with an empty FIFO.
    repeat (100) @(posedge clk);

    // Single byte, then two bytes queued together.
    push(8'h09);
    drain(400);
    push(8'h09);
    push(8'h08);
    drain(400);

    // Enable dropped mid-frame: frame completes, remaining bytes stay put.
    push(8'hA5);
    push(8'h3C);
    push(8'h5A);
    wait_start();
    repeat (10) @(posedge clk);
    #1 en = 1'b0;
    wait_idle();
    repeat (30) @(posedge clk);
    for (int d = 0; d < 2; d++) chk(fq[d].size() == 2, nm("en_hold_fifo", d), fq[d].size(), 2);
    #1 en = 1'b1;
    drain(400);

    // Reset mid-frame: first byte is lost, next one goes out after release.
    push(8'hC3);
    push(8'h7E);
    wait_start();
    repeat (17) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drain(400);

    // Random bytes, random gaps, random enable toggling, plus all-ones/zeros.
    push(8'hFF);
    push(8'h00);
    for (int i = 0; i < 60; i++) begin
      push(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 60)) @(posedge clk);
        #1 en = ($urandom_range(0, 4) != 0);
      end
    end
    @(posedge clk);
    #1 en = 1'b1;
    drain(20000);

    for (int d = 0; d < 2; d++)
      chk(exp_q[d].size() == 0, nm("leftover_expected", d), exp_q[d].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
